// File: rtl/constants.sv
// Widths and request bundle shared by the load/store requester and
// the memory-side responder.
package constants;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rsp_fifo.sv
// Power-of-two FIFO with wrap-bit pointers and a head read straight
// out of the storage registers so it holds steady until popped.
module rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] store [DEPTH];

    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (count == (AW + 1)'(DEPTH));
    assign head  = store[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (push) begin
                store[wptr[AW-1:0]] <= push_data;
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: posted writes, fixed-latency in-order reads,
// credit-throttled so the response FIFO can never overflow.
module mem_responder
    import constants::*;
#(
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m_req_vld,
    output logic                  m_req_rdy,
    input  logic                  m_req_we,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    input  logic [DATA_WIDTH-1:0] m_req_wdata,
    output logic                  m_rsp_vld,
    input  logic                  m_rsp_rdy,
    output logic [DATA_WIDTH-1:0] m_rsp_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    mem_req_t              req;
    logic [IW-1:0]         idx;
    logic                  unused_addr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         credits;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_cnt;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign req = '{we: m_req_we, addr: m_req_addr, wdata: m_req_wdata};
    assign idx = req.addr[IW-1:0];
    assign unused_addr = ^req.addr[ADDR_WIDTH-1:IW];

    assign m_req_rdy = (credits != '0);
    assign rd_acc    = m_req_vld && m_req_rdy && !req.we;
    assign wr_acc    = m_req_vld && m_req_rdy && req.we;
    assign m_rsp_vld = !fifo_empty;
    assign pop       = m_rsp_vld && m_rsp_rdy;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[idx] <= req.wdata;
        end
    end

    // The FIFO write is the final latency stage, so LATENCY-1 registers
    // sit in front of it.
    if (LATENCY == 1) begin : g_direct
        assign push      = rd_acc;
        assign push_data = mem[idx];
        assign inflight  = '0;
    end else begin : g_pipe
        logic [LATENCY-2:0]    sv;
        logic [DATA_WIDTH-1:0] sd [LATENCY-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sv <= '0;
                for (int k = 0; k < LATENCY - 1; k++) begin
                    sd[k] <= '0;
                end
            end else begin
                sv[0] <= rd_acc;
                sd[0] <= mem[idx];
                for (int k = 1; k < LATENCY - 1; k++) begin
                    sv[k] <= sv[k-1];
                    sd[k] <= sd[k-1];
                end
            end
        end

        assign push      = sv[LATENCY-2];
        assign push_data = sd[LATENCY-2];
        assign inflight  = CW'($countones(sv));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CW'(RSP_DEPTH);
        end else begin
            unique case (1'b1)
                rd_acc && !pop: credits <= credits - CW'(1);
                pop && !rd_acc: credits <= credits + CW'(1);
                default:        credits <= credits;
            endcase
        end
    end

    rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (m_rsp_data),
        .count     (fifo_cnt)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && push && !pop));

    a_credit_sum: assert property (@(posedge clk) disable iff (!rst_n)
        (inflight + fifo_cnt + credits) == CW'(RSP_DEPTH));

    a_credit_max: assert property (@(posedge clk) disable iff (!rst_n)
        credits <= CW'(RSP_DEPTH));

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's load/store port. It accepts requests on a valid/ready request channel and services them from an internal word-addressed array with fixed read latency. Read data returns in order on the `m_rsp_*` channel, which feeds the core's response skid buffer. Backpressure from that consumer is absorbed by an internal response FIFO, and a credit counter guarantees the FIFO never overflows.

## Interface
Parameters:
- `DEPTH`, default 256: number of memory words; must be a power of two.
- `LATENCY`, default 2: cycles from read acceptance to `m_rsp_vld`; ≥1.
- `RSP_DEPTH`, default 4: response FIFO entries; power of two, ≥ `LATENCY`.

Ports (widths use `constants::DATA_WIDTH`, `constants::ADDR_WIDTH`):
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_req_vld` in 1: request valid.
- `m_req_rdy` out 1: request ready.
- `m_req_we` in 1: 1 = write, 0 = read.
- `m_req_addr` in ADDR_WIDTH: word address; the low log2(DEPTH) bits are used and the upper bits are ignored.
- `m_req_wdata` in DATA_WIDTH: write data.
- `m_rsp_vld` out 1: response valid.
- `m_rsp_rdy` in 1: consumer ready.
- `m_rsp_data` out DATA_WIDTH: read data.

## Operation
- **Request handshake.** A request transfers in any cycle where `m_req_vld && m_req_rdy`.
- **Ready rule.** `m_req_rdy = (credits != 0)`. It does not depend on `m_req_vld` or `m_req_we`.
- **Writes.** Posted: memory is updated at the acceptance edge. A write consumes no credit and produces no response.
- **Reads.**
  - Read the addressed word at the acceptance edge.
  - Carry it through a `LATENCY`-stage valid/data pipeline.
  - Push it into the response FIFO when it leaves the last stage.
- **Credits.** Count range is 0..`RSP_DEPTH`; reset value is `RSP_DEPTH`.
  - Decrement on read acceptance.
  - Increment on response pop (`m_rsp_vld && m_rsp_rdy`).
  - If both happen in the same cycle, the count is unchanged.
  - Invariant: in-flight reads + FIFO occupancy + credits = `RSP_DEPTH`.
- **Response channel.**
  - `m_rsp_vld` = FIFO non-empty; `m_rsp_data` = FIFO head.
  - Once asserted, `m_rsp_vld` and `m_rsp_data` hold stable until popped.
  - Responses leave in request order.
- **FIFO boundaries.**
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Full-with-push-without-pop is impossible by credit construction; flag it with an assertion.
  - Read/write pointers are log2(RSP_DEPTH)+1 bits and wrap naturally.
- **Address wrap.** Addresses ≥ DEPTH alias modulo DEPTH.

## Timing
- **Reset** (asynchronous assert, synchronous deassert as seen at `clk`):
  - `m_req_rdy` = 1, `m_rsp_vld` = 0, `m_rsp_data` = 0.
  - Credits = `RSP_DEPTH`; pipeline valids = 0; FIFO pointers = 0.
  - Memory contents are not reset.
- **Reset mid-operation:** in-flight reads and queued responses are discarded; no response appears after reset.
- **Read latency:** for a read accepted in cycle T, `m_rsp_vld` is high in cycle T+`LATENCY` if the FIFO was empty and the response channel was idle. Otherwise the response appears later, queued in order.
- **Throughput:** one read per cycle sustained while `m_rsp_rdy` stays high and `RSP_DEPTH` ≥ `LATENCY`+1. With `RSP_DEPTH` = `LATENCY`, expect one bubble every `RSP_DEPTH`+1 cycles.
- **Write visibility:** a write accepted in cycle T is visible to a read accepted in T+1 or later.
- **Stall:** `m_req_rdy` falls in the cycle after the credit that empties the count is consumed. It rises in the cycle after a pop.

## Structure
- The shared `constants` package holds `DATA_WIDTH`, `ADDR_WIDTH` and the request struct typedef `mem_req_t` {we, addr, wdata}, shared with the core-side requester.
- One sub-module, `rsp_fifo`:
  - Parameterized by width and depth.
  - Push/pop, full/empty, registered head.
  - Reused elsewhere in the codebase.
- The top level holds the memory array, read pipeline, credit counter and assertions.

## Test plan
- **Reset, then single read.** Write 0xDEADBEEF to addr 5 at T0; read addr 5 at T1 with `m_rsp_rdy`=1 → `m_rsp_vld` at T1+2 with data 0xDEADBEEF, high for exactly one cycle.
- **Backpressure fill.** `m_rsp_rdy`=0; issue reads to addrs 0..5 back-to-back → exactly 4 accepted, `m_req_rdy`=0 from the 5th cycle. Then raise `m_rsp_rdy` → data for addrs 0,1,2,3 in order, `m_req_rdy` re-asserts the cycle after the first pop.
- **Streaming.** `RSP_DEPTH`=4, `LATENCY`=2, `m_rsp_rdy`=1; 16 consecutive reads → 16 responses on 16 consecutive cycles, with no `m_req_rdy` deassertion.
- **Full with simultaneous push/pop.** Toggle `m_rsp_rdy` every cycle while reading continuously → no loss or duplication, order preserved, credit invariant holds every cycle.
- **Address aliasing.** `DEPTH`=256; write 0x11 to addr 0x105, read addr 0x005 → 0x11.
- **Reset mid-flight.** Accept 3 reads and assert `rst_n`=0 for one cycle → outputs at reset values immediately, no stale `m_rsp_vld` afterwards, credits = 4.
